// File: rtl/bextdep_pkg.sv
// Shared definitions for the bit-extract/deposit arbiter slice: mode codes,
// a constant clog2 and the requester tag width.
package bextdep_pkg;

  localparam logic [1:0] MODE_BEXT  = 2'd0;
  localparam logic [1:0] MODE_BDEP  = 2'd1;
  localparam logic [1:0] MODE_BEXTR = 2'd2;
  localparam logic [1:0] MODE_BDEPR = 2'd3;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Sized for the largest legal requester count so every NREQ shares one tag width.
  localparam int NREQ_MAX = 8;
  localparam int TAGW     = clog2(NREQ_MAX);

endpackage

// File: rtl/bextdep_tagfifo.sv
// In-order FIFO of requester tags for requests currently inside the unit.
module bextdep_tagfifo
  import bextdep_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TW    = 3
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   i_push,
  input  logic [TW-1:0]          i_push_tag,
  input  logic                   i_pop,
  output logic [TW-1:0]          o_head,
  output logic [clog2(DEPTH):0]  o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int AW = clog2(DEPTH);

  logic [TW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd];
  assign o_count   = r_count;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) r_wr <= r_wr + 1'b1;
      if (w_pop_ok)  r_rd <= r_rd + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (w_push_ok) r_mem[r_wr] <= i_push_tag;
  end

endmodule

// File: rtl/bextdep_arbiter.sv
// Round-robin sharing of one bit-extract/deposit unit among NREQ requesters;
// results are steered back to their owners using the in-order tag FIFO.
module bextdep_arbiter
  import bextdep_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREQ  = 4,
  parameter int DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [2*NREQ-1:0]    req_mode,
  input  logic [XLEN*NREQ-1:0] req_value,
  input  logic [XLEN*NREQ-1:0] req_mask,
  output logic [NREQ-1:0]      rsp_valid,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic [XLEN-1:0]      rsp_result,
  output logic                 unit_din_valid,
  input  logic                 unit_din_ready,
  output logic [1:0]           unit_din_mode,
  output logic [XLEN-1:0]      unit_din_value,
  output logic [XLEN-1:0]      unit_din_mask,
  input  logic                 unit_dout_valid,
  output logic                 unit_dout_ready,
  input  logic [XLEN-1:0]      unit_dout_result,
  output logic                 err_orphan
);

  localparam int              CW     = clog2(DEPTH) + 1;
  localparam logic [TAGW:0]   NREQ_W = (TAGW+1)'(NREQ);
  localparam logic [TAGW-1:0] LAST   = TAGW'(NREQ - 1);

  logic [TAGW-1:0]   r_rr;
  logic              r_err_orphan;
  logic [2*NREQ-1:0] w_shift;
  logic [TAGW:0]     w_sum;
  logic [TAGW-1:0]   w_g;
  logic              w_found;
  logic              w_grant_en;
  logic              w_push;
  logic              w_pop;
  logic              w_rsp_en;
  logic              w_head_ready;
  logic [TAGW-1:0]   w_head;
  logic [CW-1:0]     w_count;
  logic              w_full;
  logic              w_empty;

  // Rotating the doubled request vector by rr puts the search start at bit 0.
  assign w_shift = {req_valid, req_valid} >> r_rr;

  always_comb begin
    w_found = 1'b0;
    w_sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_found && w_shift[k]) begin
        w_found = 1'b1;
        w_sum   = {1'b0, r_rr} + (TAGW+1)'(k);
      end
    end
    if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
    w_g = w_sum[TAGW-1:0];
  end

  assign w_grant_en     = reset && w_found && !w_full;
  assign unit_din_valid = w_grant_en;
  assign w_push         = w_grant_en && unit_din_ready;
  assign w_rsp_en       = reset && unit_dout_valid && !w_empty;
  assign unit_dout_ready = reset && !w_empty && w_head_ready;
  assign w_pop          = unit_dout_valid && unit_dout_ready;
  assign rsp_result     = unit_dout_result;
  assign err_orphan     = r_err_orphan;

  always_comb begin
    unit_din_mode  = '0;
    unit_din_value = '0;
    unit_din_mask  = '0;
    req_ready      = '0;
    rsp_valid      = '0;
    w_head_ready   = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_g == TAGW'(k)) begin
        unit_din_mode  = req_mode[2*k +: 2];
        unit_din_value = req_value[XLEN*k +: XLEN];
        unit_din_mask  = req_mask[XLEN*k +: XLEN];
        req_ready[k]   = w_grant_en && unit_din_ready;
      end
      if (w_head == TAGW'(k)) begin
        w_head_ready = rsp_ready[k];
        rsp_valid[k] = w_rsp_en;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_rr         <= '0;
      r_err_orphan <= 1'b0;
    end else begin
      if (w_push) r_rr <= (w_g == LAST) ? '0 : w_g + 1'b1;
      if (unit_dout_valid && w_empty) r_err_orphan <= 1'b1;
    end
  end

  bextdep_tagfifo #(
    .DEPTH (DEPTH),
    .TW    (TAGW)
  ) u_tagfifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_tag (w_g),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

endmodule
